// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: packet-id width and the TX message scheduler state encoding.
// The scheduler and its sub-blocks import this package.
package chiplet_types_pkg;

   localparam int PKT_ID_W    = 2;
   localparam int NUM_PKT_IDS = 1 << PKT_ID_W;

   typedef logic [PKT_ID_W-1:0] pkt_id_t;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_ISSUE,
      SCHED_WAIT,
      SCHED_RETIRE
   } tx_sched_state_e;

endpackage

// File: rtl/socetlib_counter.sv
// Saturating up-counter with a synchronous clear and a count enable.
// Clear takes priority over enable.
module socetlib_counter #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state always uses non-blocking assignments so that every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_enable && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Combinational rotating-priority picker.
// The search starts at ptr and moves upward with wrap; the first set request wins.
module tx_rr_arbiter #(
   parameter int NUM_MSGS = 4,
   parameter int ID_W     = $clog2(NUM_MSGS)
) (
   input  logic [NUM_MSGS-1:0] req,
   input  logic [ID_W-1:0]     ptr,
   output logic [ID_W-1:0]     grant_id,
   output logic                grant_valid
);

   // NOTE: every output gets a default before the loop, so no path through the block can infer a latch.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      // Walk from the farthest offset down so the offset nearest ptr is written last.
      for (int i = NUM_MSGS - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NUM_MSGS]) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'((int'(ptr) + i) % NUM_MSGS);
         end
      end
   end

endmodule

// File: rtl/tx_msg_scheduler.sv
// Picks one eligible message slot at a time (round-robin), triggers the TX FSM, waits for
// the packet to finish and retires the slot; a watchdog aborts a transfer that never completes.
module tx_msg_scheduler
   import chiplet_types_pkg::*;
#(
   parameter int NUM_MSGS       = NUM_PKT_IDS,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_W          = $clog2(NUM_MSGS),
   localparam int CNT_W         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_MSGS-1:0] msg_pending,
   input  logic [NUM_MSGS-1:0] msg_enable,
   input  logic                tx_idle,
   input  logic                tx_done,
   input  logic                err_clear,
   output logic [NUM_MSGS-1:0] trigger_send,
   output logic [NUM_MSGS-1:0] msg_clear,
   output logic [ID_W-1:0]     curr_id,
   output logic                busy,
   output logic                timeout_err
);

   tx_sched_state_e state_q, state_d;
   logic [ID_W-1:0]     curr_id_q, rr_ptr_q, next_ptr;
   logic [ID_W-1:0]     grant_id;
   logic                grant_valid;
   logic                grant_take;
   logic                timeout_hit;
   logic                timeout_err_q;
   logic [NUM_MSGS-1:0] eligible;
   logic [CNT_W-1:0]    wd_count;

   assign eligible   = msg_pending & msg_enable;
   assign grant_take = (state_q == SCHED_IDLE) && grant_valid && tx_idle;
   assign next_ptr   = (curr_id_q == ID_W'(NUM_MSGS - 1)) ? '0 : curr_id_q + 1'b1;

   tx_rr_arbiter #(
      .NUM_MSGS (NUM_MSGS),
      .ID_W     (ID_W)
   ) u_arbiter (
      .req         (eligible),
      .ptr         (rr_ptr_q),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   socetlib_counter #(
      .WIDTH (CNT_W),
      .MAX   (CNT_W'(TIMEOUT_CYCLES))
   ) u_watchdog (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (state_q == SCHED_ISSUE),
      .count_enable (state_q == SCHED_WAIT),
      .count        (wd_count)
   );

   // Fire on the last allowed WAIT cycle so WAIT lasts exactly TIMEOUT_CYCLES cycles.
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_watchdog
         assign timeout_hit = (state_q == SCHED_WAIT) && (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_watchdog
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= SCHED_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SCHED_IDLE:   if (grant_take) state_d = SCHED_ISSUE;
         SCHED_ISSUE:  state_d = SCHED_WAIT;
         SCHED_WAIT: begin
            if (timeout_hit) begin
               state_d = SCHED_IDLE;
            end else if (tx_done) begin
               state_d = SCHED_RETIRE;
            end
         end
         SCHED_RETIRE: state_d = SCHED_IDLE;
         default:      state_d = SCHED_IDLE;
      endcase
   end

   always_comb begin
      trigger_send = '0;
      msg_clear    = '0;
      busy         = (state_q != SCHED_IDLE);
      if (state_q == SCHED_ISSUE) trigger_send[curr_id_q] = 1'b1;
      if (state_q == SCHED_RETIRE) msg_clear[curr_id_q] = 1'b1;
   end

   // A timeout moves the pointer past the stuck slot without clearing it, so it is retried last.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         curr_id_q     <= '0;
         rr_ptr_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (grant_take) curr_id_q <= grant_id;
         if ((state_q == SCHED_RETIRE) || timeout_hit) rr_ptr_q <= next_ptr;
         if (timeout_hit) begin
            timeout_err_q <= 1'b1;
         end else if (err_clear) begin
            timeout_err_q <= 1'b0;
         end
      end
   end

   assign curr_id     = curr_id_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tx_msg_scheduler.sv
// Scoreboard bench for tx_msg_scheduler: stimulus queues expected trigger/clear pulses,
// a negedge monitor pops and compares them, direct checks cover busy, errors and reset.
module tb_tx_msg_scheduler;

   localparam int N  = 4;
   localparam int TO = 8;

   typedef struct {
      bit         is_clr;
      logic [N-1:0] vec;
      int         id;
      int         cyc;
   } ev_t;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic [N-1:0] msg_pending = '0;
   logic [N-1:0] msg_enable = '0;
   logic         tx_idle = 1'b0;
   logic         tx_done = 1'b0;
   logic         err_clear = 1'b0;
   logic [N-1:0] trigger_send;
   logic [N-1:0] msg_clear;
   logic [1:0]   curr_id;
   logic         busy;
   logic         timeout_err;

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   ev_t exp_q[$];

   tx_msg_scheduler #(
      .NUM_MSGS       (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .msg_pending  (msg_pending),
      .msg_enable   (msg_enable),
      .tx_idle      (tx_idle),
      .tx_done      (tx_done),
      .err_clear    (err_clear),
      .trigger_send (trigger_send),
      .msg_clear    (msg_clear),
      .curr_id      (curr_id),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected pulse one cycle after the current one.
   task automatic push_ev(input bit is_clr, input logic [N-1:0] vec);
      ev_t e;
      e.is_clr = is_clr;
      e.vec    = vec;
      e.id     = 0;
      for (int i = 0; i < N; i++) if (vec[i]) e.id = i;
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if ((trigger_send | msg_clear) != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {24'd0, msg_clear, trigger_send}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check(e.is_clr ? "clear_vec" : "trigger_vec", {24'd0, msg_clear, trigger_send},
                  e.is_clr ? {24'd0, e.vec, 4'd0} : {28'd0, e.vec});
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_curr_id", {30'd0, curr_id}, e.id);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_trigger"}, {28'd0, trigger_send}, 32'd0);
      check({tag, "_clear"}, {28'd0, msg_clear}, 32'd0);
      check({tag, "_curr_id"}, {30'd0, curr_id}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_err"}, {31'd0, timeout_err}, 32'd0);
   endtask

   task automatic do_reset();
      n_rst       = 1'b0;
      msg_pending = '0;
      msg_enable  = '0;
      tx_idle     = 1'b0;
      tx_done     = 1'b0;
      err_clear   = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #3;
      n_rst = 1'b1;
      tick();
   endtask

   // Called in an IDLE cycle whose inputs already make exp_vec the winner.
   task automatic xfer(input logic [N-1:0] exp_vec, input int done_after, input bit drop);
      push_ev(1'b0, exp_vec);
      tick();
      check("busy_issue", {31'd0, busy}, 32'd1);
      repeat (done_after) tick();
      tx_done = 1'b1;
      push_ev(1'b1, exp_vec);
      tick();
      tx_done = 1'b0;
      if (drop) msg_pending = msg_pending & ~exp_vec;
      check("busy_retire", {31'd0, busy}, 32'd1);
      tick();
      check("busy_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Reset and single slot; the follow-up grants show the pointer moved to 1.
      do_reset();
      msg_pending = 4'b0001;
      msg_enable  = 4'b1111;
      tx_idle     = 1'b1;
      xfer(4'b0001, 5, 1'b1);
      msg_pending = 4'b0011;
      xfer(4'b0010, 2, 1'b1);
      xfer(4'b0001, 2, 1'b1);

      // Fairness with every slot pending.
      do_reset();
      msg_pending = 4'b1111;
      msg_enable  = 4'b1111;
      tx_idle     = 1'b1;
      xfer(4'b0001, 3, 1'b0);
      xfer(4'b0010, 3, 1'b0);
      xfer(4'b0100, 3, 1'b0);
      xfer(4'b1000, 3, 1'b0);
      xfer(4'b0001, 3, 1'b0);

      // Mask, then hold off while the TX FSM is not idle.
      do_reset();
      msg_pending = 4'b0110;
      msg_enable  = 4'b0100;
      tx_idle     = 1'b0;
      repeat (4) tick();
      check("no_grant_tx_busy", {31'd0, busy}, 32'd0);
      tx_idle = 1'b1;
      xfer(4'b0100, 2, 1'b1);

      // Timeout on slot 1 with err_clear in the same cycle; slot 2 goes next, then slot 1 retries.
      do_reset();
      msg_pending = 4'b0010;
      msg_enable  = 4'b1111;
      tx_idle     = 1'b1;
      push_ev(1'b0, 4'b0010);
      tick();
      msg_pending = 4'b0110;
      repeat (TO - 1) tick();
      check("err_before_timeout", {31'd0, timeout_err}, 32'd0);
      tick();
      check("err_last_wait", {31'd0, timeout_err}, 32'd0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("err_set_wins", {31'd0, timeout_err}, 32'd1);
      check("idle_after_timeout", {31'd0, busy}, 32'd0);
      xfer(4'b0100, 2, 1'b1);
      xfer(4'b0010, 2, 1'b1);
      check("err_sticky", {31'd0, timeout_err}, 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("err_cleared", {31'd0, timeout_err}, 32'd0);

      // tx_done on the cycle the watchdog expires: timeout wins, no clear.
      do_reset();
      msg_pending = 4'b0010;
      msg_enable  = 4'b1111;
      tx_idle     = 1'b1;
      push_ev(1'b0, 4'b0010);
      tick();
      repeat (TO) tick();
      tx_done = 1'b1;
      tick();
      tx_done     = 1'b0;
      msg_pending = '0;
      check("done_vs_timeout_err", {31'd0, timeout_err}, 32'd1);
      check("done_vs_timeout_idle", {31'd0, busy}, 32'd0);
      repeat (3) tick();

      // Reset mid-WAIT on slot 2 (timeout_err still set), then slot 3 after release.
      msg_pending = 4'b0100;
      push_ev(1'b0, 4'b0100);
      tick();
      msg_pending = 4'b1000;
      repeat (2) tick();
      check("busy_mid_wait", {31'd0, busy}, 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(posedge clk);
      @(posedge clk);
      #3;
      n_rst = 1'b1;
      push_ev(1'b0, 4'b1000);
      tick();
      repeat (2) tick();
      tx_done = 1'b1;
      push_ev(1'b1, 4'b1000);
      tick();
      tx_done     = 1'b0;
      msg_pending = '0;
      repeat (3) tick();

      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
